// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VGA timing constants, framebuffer geometry, pixel width and arbiter FSM encoding.
package vram_arbiter_pkg;
   localparam int VGA_H_BEFORE = 144;
   localparam int VGA_V_BEFORE = 35;
   localparam int VGA_FB_W     = 160;
   localparam int VGA_FB_DEPTH = 19200;
   localparam int RGB_W        = 12;
   localparam int ADDR_W       = 15;
   localparam int POS_W        = 12;
   typedef enum logic [1:0] {IDLE, DISP, WRITE, TURN} arb_state_t;
endpackage

// File: rtl/vram_addr_gen.sv
// vram_addr_gen: combinational scan position to framebuffer word address (one word per 4x4 pixel block).
module vram_addr_gen
   import vram_arbiter_pkg::*;
#(
   parameter int H_BEFORE = VGA_H_BEFORE,
   parameter int V_BEFORE = VGA_V_BEFORE,
   parameter int FB_W     = VGA_FB_W
)(
   input  logic [POS_W-1:0]  x_poi,
   input  logic [POS_W-1:0]  y_poi,
   output logic [ADDR_W-1:0] addr
);
   logic [POS_W-1:0]  x_rel, y_rel;
   logic [ADDR_W-1:0] col, row;
   assign x_rel = x_poi - POS_W'(H_BEFORE);
   assign y_rel = y_poi - POS_W'(V_BEFORE);
   assign col   = ADDR_W'(x_rel >> 2);
   assign row   = ADDR_W'(y_rel >> 2);
   // 160 = 128 + 32, so the row stride needs no multiplier
   if (FB_W == 160) begin : g_shift
      assign addr = (row << 7) + (row << 5) + col;
   end else begin : g_mul
      assign addr = ADDR_W'(int'(row) * FB_W) + col;
   end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between VGA scanout fetch and a drawing client.
// Define VRAM_BLANK_WR_ONLY_EN to restrict client writes to the blanking interval.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int H_BEFORE = VGA_H_BEFORE,
   parameter int V_BEFORE = VGA_V_BEFORE,
   parameter int FB_W     = VGA_FB_W,
   parameter int FB_DEPTH = VGA_FB_DEPTH
)(
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic [POS_W-1:0]  x_poi,
   input  logic [POS_W-1:0]  y_poi,
   input  logic              is_display,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [RGB_W-1:0]  wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [RGB_W-1:0]  ram_wdata,
   input  logic [RGB_W-1:0]  ram_rdata,
   output logic [RGB_W-1:0]  pixel_rgb,
   output logic              disp_valid
);
   arb_state_t        state, state_nx;
   logic [ADDR_W-1:0] fetch_addr;
   logic [1:0]        phase;
   logic              fetch_slot, wr_ok, wr_bad, bad_q, disp_d1, rd_valid;
   logic [RGB_W-1:0]  pix_hold;

   vram_addr_gen #(
      .H_BEFORE(H_BEFORE),
      .V_BEFORE(V_BEFORE),
      .FB_W(FB_W)
   ) u_addr_gen (
      .x_poi(x_poi),
      .y_poi(y_poi),
      .addr(fetch_addr)
   );

   assign phase      = x_poi[1:0] - 2'(H_BEFORE);
   assign fetch_slot = is_display && (phase == 2'b00);
   assign wr_bad     = int'(wr_addr) >= FB_DEPTH;
`ifdef VRAM_BLANK_WR_ONLY_EN
   assign wr_ok = wr_req && !is_display;
`else
   assign wr_ok = wr_req;
`endif

   always_ff @(posedge vga_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // A fetch slot pre-empts everything, including the TURN that normally follows a write
   always_comb
      state_nx = fetch_slot                    ? DISP
               : (state == WRITE)              ? TURN
               : (wr_ok && state != TURN)      ? WRITE
               : IDLE;

   always_comb begin
      wr_ack = (state == WRITE);
      wr_err = wr_ack && bad_q;
      ram_we = wr_ack && !bad_q;
   end

   always_ff @(posedge vga_clk or negedge rst_n)
      if (!rst_n) begin
         ram_addr   <= '0;
         ram_wdata  <= '0;
         bad_q      <= 1'b0;
         disp_d1    <= 1'b0;
         disp_valid <= 1'b0;
         rd_valid   <= 1'b0;
         pix_hold   <= '0;
      end else begin
         if (state_nx == DISP) ram_addr <= fetch_addr;
         if (state_nx == WRITE) begin
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
            bad_q     <= wr_bad;
         end
         disp_d1    <= is_display;
         disp_valid <= disp_d1;
         rd_valid   <= (state == DISP);
         if (rd_valid) pix_hold <= ram_rdata;
      end

   // The freshly read word is shown directly in its first pixel, then held for the other three
   assign pixel_rgb = !disp_valid ? '0 : rd_valid ? ram_rdata : pix_hold;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed table-driven bench for vram_arbiter with a synchronous-read RAM model.
module tb_vram_arbiter;
   typedef struct {
      int x, y, d, wr, wa, wd;
      int we, ack, err, ca, ea, pix, dv;
   } vec_t;

   localparam int NV = 26;

   logic        vga_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] x_poi = '0, y_poi = '0;
   logic        is_display = 1'b0, wr_req = 1'b0;
   logic [14:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic        wr_ack, wr_err, ram_we, disp_valid;
   logic [14:0] ram_addr, ag_addr;
   logic [11:0] ram_wdata, ram_rdata, pixel_rgb;
   logic [11:0] ag_x = '0, ag_y = '0;
   logic [11:0] mem [0:32767] = '{default: 12'h000};
   int          checks = 0, failures = 0;
   vec_t        tbl [NV];

   always #5 vga_clk = ~vga_clk;

   vram_arbiter dut (
      .vga_clk(vga_clk), .rst_n(rst_n), .x_poi(x_poi), .y_poi(y_poi),
      .is_display(is_display), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pixel_rgb(pixel_rgb),
      .disp_valid(disp_valid)
   );

   vram_addr_gen ag (.x_poi(ag_x), .y_poi(ag_y), .addr(ag_addr));

   // RAM model: read-first, one-cycle read latency; image words preloaded while in reset
   always @(posedge vga_clk) begin
      if (!rst_n) begin
         mem[0]     <= 12'hF00;
         mem[1]     <= 12'h0AB;
         mem[6599]  <= 12'h123;
         mem[19199] <= 12'hABC;
      end else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick;
      @(posedge vga_clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
      end
   endtask

   function automatic vec_t v(int x, int y, int d, int wr, int wa, int wd,
                              int we, int ack, int err, int ca, int ea, int pix, int dv);
      vec_t r;
      r = '{x, y, d, wr, wa, wd, we, ack, err, ca, ea, pix, dv};
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl = '{
         v(144,  35, 1, 0,     0,     0, 0, 0, 0, 1,     0, 0,      0),
         v(145,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'hF00,  1),
         v(146,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'hF00,  1),
         v(147,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'hF00,  1),
         v(148,  35, 1, 0,     0,     0, 0, 0, 0, 1,     1, 'hF00,  1),
         v(149,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0AB,  1),
         v(150,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0AB,  1),
         v(151,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0AB,  1),
         v(300, 200, 1, 0,     0,     0, 0, 0, 0, 1,  6599, 'h0AB,  1),
         v(301, 200, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h123,  1),
         v(148,  35, 1, 1,   100, 'h0F0, 0, 0, 0, 1,     1, 'h123,  1),
         v(149,  35, 1, 1,   100, 'h0F0, 1, 1, 0, 1,   100, 'h0AB,  1),
         v(150,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0AB,  1),
         v(151,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0AB,  1),
         v( 10,  10, 0, 1,   100, 'h0F0, 1, 1, 0, 1,   100, 'h0AB,  1),
         v( 11,  10, 0, 1,   100, 'h0F0, 0, 0, 0, 0,     0, 0,      0),
         v( 12,  10, 0, 1,   100, 'h0F0, 0, 0, 0, 0,     0, 0,      0),
         v( 13,  10, 0, 0,     0,     0, 0, 0, 0, 0,     0, 0,      0),
         v( 14,  10, 0, 1, 19200, 'hFFF, 0, 1, 1, 0,     0, 0,      0),
         v( 15,  10, 0, 0,     0,     0, 0, 0, 0, 0,     0, 0,      0),
         v(780, 514, 1, 0,     0,     0, 0, 0, 0, 1, 19199, 0,      0),
         v(781, 514, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'hABC,  1),
         v(144,  35, 1, 0,     0,     0, 0, 0, 0, 1,     0, 'hABC,  1),
         v(145,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'hF00,  1),
         v(544,  35, 1, 0,     0,     0, 0, 0, 0, 1,   100, 'hF00,  1),
         v(545,  35, 1, 0,     0,     0, 0, 0, 0, 0,     0, 'h0F0,  1)
      };

      tick;
      tick;
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_ack", 32'(wr_ack), 0);
      chk("rst_err", 32'(wr_err), 0);
      chk("rst_pix", 32'(pixel_rgb), 0);
      chk("rst_dv", 32'(disp_valid), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_wdata", 32'(ram_wdata), 0);

      ag_x = 12'd783; ag_y = 12'd514; #1;
      chk("ag_last", 32'(ag_addr), 19199);
      ag_x = 12'd144; ag_y = 12'd35; #1;
      chk("ag_first", 32'(ag_addr), 0);
      ag_x = 12'd148; ag_y = 12'd39; #1;
      chk("ag_row1", 32'(ag_addr), 161);

      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         x_poi = 12'(tbl[i].x);
         y_poi = 12'(tbl[i].y);
         is_display = tbl[i].d[0];
         wr_req = tbl[i].wr[0];
         wr_addr = 15'(tbl[i].wa);
         wr_data = 12'(tbl[i].wd);
         tick;
         chk($sformatf("r%0d_we", i), 32'(ram_we), tbl[i].we);
         chk($sformatf("r%0d_ack", i), 32'(wr_ack), tbl[i].ack);
         chk($sformatf("r%0d_err", i), 32'(wr_err), tbl[i].err);
         chk($sformatf("r%0d_pix", i), 32'(pixel_rgb), tbl[i].pix);
         chk($sformatf("r%0d_dv", i), 32'(disp_valid), tbl[i].dv);
         if (tbl[i].ca != 0) chk($sformatf("r%0d_addr", i), 32'(ram_addr), tbl[i].ea);
         if (tbl[i].we != 0) chk($sformatf("r%0d_wdata", i), 32'(ram_wdata), tbl[i].wd);
      end

      x_poi = 12'd20; y_poi = 12'd20; is_display = 1'b0;
      wr_req = 1'b1; wr_addr = 15'd200; wr_data = 12'h555;
      tick;
      chk("rw_we", 32'(ram_we), 1);
      chk("rw_ack", 32'(wr_ack), 1);
      chk("rw_addr", 32'(ram_addr), 200);
      rst_n = 1'b0;
      #1;
      chk("rw_rst_we", 32'(ram_we), 0);
      chk("rw_rst_ack", 32'(wr_ack), 0);
      chk("rw_rst_pix", 32'(pixel_rgb), 0);
      chk("rw_rst_dv", 32'(disp_valid), 0);
      chk("rw_rst_addr", 32'(ram_addr), 0);
      chk("rw_rst_wdata", 32'(ram_wdata), 0);
      wr_req = 1'b0;
      tick;
      rst_n = 1'b1;
      x_poi = 12'd148; y_poi = 12'd35; is_display = 1'b1;
      tick;
      chk("rw_fetch_addr", 32'(ram_addr), 1);
      chk("rw_fetch_we", 32'(ram_we), 0);
      chk("rw_fetch_dv", 32'(disp_valid), 0);
      x_poi = 12'd149;
      tick;
      chk("rw_pix", 32'(pixel_rgb), 12'h0AB);
      chk("rw_dv", 32'(disp_valid), 1);
      chk("rw_no_write", 32'(mem[200]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter H_BEFORE, 144, first active horizontal count.
REQ-002 Parameter V_BEFORE, 35, first active vertical count.
REQ-003 Parameter FB_W, 160, framebuffer width in words (640/4).
REQ-004 Parameter FB_DEPTH, 19200, framebuffer words (160x120).
REQ-005 Port vga_clk  in  1  the single clock, all logic on rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports x_poi, y_poi  in  12 each  current scan counters from the timing generator.
REQ-008 Port is_display  in  1  scan position is in the visible 640x480 window.
REQ-009 Ports wr_req in 1, wr_addr in 15, wr_data in 12: drawing-client write request, address and RGB444 data.
REQ-010 Port wr_ack  out  1  one-cycle pulse, request consumed.
REQ-011 Port wr_err  out  1  one-cycle pulse with wr_ack when wr_addr >= FB_DEPTH.
REQ-012 Ports ram_addr out 15, ram_we out 1, ram_wdata out 12, ram_rdata in 12: single-port RAM, 1-cycle synchronous read.
REQ-013 Ports pixel_rgb out 12, disp_valid out 1: scanout pixel and its visible flag.

Function
REQ-014 Display fetch slot SHALL be a cycle with is_display=1 and (x_poi-H_BEFORE)[1:0]==0; display always wins that slot.
REQ-015 Fetch address SHALL be ((y_poi-V_BEFORE)>>2)*160 + ((x_poi-H_BEFORE)>>2), built with shifts/adds (<<7 plus <<5), 15-bit result.
REQ-016 All RAM port outputs SHALL be registered: decision at cycle t appears on ram_* at t+1.
REQ-017 FSM states IDLE, DISP, WRITE, TURN; IDLE->DISP on fetch slot; IDLE->WRITE on wr_req in non-fetch slot; WRITE->TURN always; TURN->DISP on fetch slot else IDLE; DISP->DISP/WRITE/IDLE by same rules as IDLE.
REQ-018 In WRITE, ram_we=1 and wr_ack=1 in the same cycle; ram_addr/ram_wdata equal sampled wr_addr/wr_data.
REQ-019 TURN SHALL block any write grant for one cycle so a held wr_req is not written twice.
REQ-020 wr_addr >= FB_DEPTH: wr_ack and wr_err pulse, ram_we stays 0.
REQ-021 Fetched word SHALL be latched into pixel_rgb one cycle after ram_rdata is valid and held for 4 pixels; total latency x_poi -> pixel_rgb is 2 cycles.
REQ-022 disp_valid SHALL equal is_display delayed 2 cycles; pixel_rgb SHALL be 0 whenever disp_valid=0.
REQ-023 wr_req/wr_addr/wr_data SHALL be held stable by the client until wr_ack; deassertion before ack is allowed and cancels the request.
REQ-024 Write and fetch in the same cycle SHALL never occur; a write pending at a fetch slot waits.

Reset
REQ-025 rst_n=0 SHALL immediately force FSM=IDLE and all outputs to 0 (ram_we, wr_ack, wr_err, pixel_rgb, disp_valid, ram_addr, ram_wdata).
REQ-026 Reset during WRITE SHALL abort with no wr_ack; the client re-requests after rst_n rises.
REQ-027 First fetch after release SHALL occur at the first qualifying slot, no warm-up.

Configuration
REQ-028 Macro VRAM_BLANK_WR_ONLY_EN defined: writes granted only when is_display=0.
REQ-029 Macro undefined: writes also granted in non-fetch slots of the active window (3 of 4 cycles).

Structure
REQ-030 Shared package holds timing constants (H_BEFORE, V_BEFORE, FB_W, FB_DEPTH), the FSM state encoding and RGB444 width.
REQ-031 One sub-module, vram_addr_gen: combinational x/y to framebuffer address.

Verification
REQ-032 Scan x=144,y=35, RAM word 0 = 12'hF00 -> ram_addr=0 at t+1, pixel_rgb=12'hF00 at t+2 for 4 cycles, disp_valid=1.
REQ-033 Scan x=783,y=514 -> ram_addr=19199; next slot wraps to x=144,y=35 -> ram_addr=0.
REQ-034 wr_req held, addr=100, data=12'h0F0, during blanking -> one ram_we/wr_ack pulse, TURN cycle, no second write.
REQ-035 wr_req asserted at x=148 (fetch slot), macro undefined -> fetch at t+1, write at t+2.
REQ-036 wr_addr=19200 -> wr_ack=1, wr_err=1, ram_we=0.
REQ-037 rst_n pulsed low during WRITE -> ram_we and wr_ack 0 immediately; pixel_rgb=0; normal fetch resumes at next slot.
